// File: rtl/shift_seq_if.sv
// ---------------------------------------------------------------------------
// shift_seq_if
//   Request/response bundle for the multi-cycle shift unit.
//
//   Request side  : in_valid, in_ready, in_data, in_amt, in_op
//   Response side : out_valid, out_ready, out_data
//
//   master modport : the client that issues shift requests and takes results
//   slave modport  : the shift unit itself
// ---------------------------------------------------------------------------
interface shift_seq_if #(
  parameter int WIDTH = 8
);
  localparam int SW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SW-1:0]    in_amt;
  logic [1:0]       in_op;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_amt,
    output in_op,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_amt,
    input  in_op,
    output out_valid,
    input  out_ready,
    output out_data
  );
endinterface

// File: rtl/shift_seq.sv
// ---------------------------------------------------------------------------
// shift_seq
//   Sequential shifter: applies a shift of 0..WIDTH-1 positions one bit per
//   clock. Supports logical left, logical right, arithmetic right and
//   rotate right. One operation in flight at a time.
//
//   Ports:
//     clk    in  rising-edge clock
//     rst_n  in  asynchronous active-low reset
//     bus    slave modport of shift_seq_if:
//              in_valid/in_ready  request handshake
//              in_data            operand
//              in_amt             unsigned shift amount (log2(WIDTH) bits)
//              in_op              00 SLL, 01 SRL, 10 SRA, 11 ROR
//              out_valid/out_ready result handshake
//              out_data           result (meaningful while out_valid)
//
//   Latency: out_valid rises in_amt cycles after the accepting edge
//   (one cycle for a zero shift). All outputs are decoded from registers,
//   so there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module shift_seq #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  shift_seq_if.slave  bus
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SW-1:0]    r_cnt;
  logic [1:0]       r_op;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_work_nxt;
  logic [SW-1:0]    w_cnt_nxt;
  logic [1:0]       w_op_nxt;

  // One-position step of the selected operation.
  function automatic logic [WIDTH-1:0] f_step(
    input logic [WIDTH-1:0] w,
    input logic [1:0]       op
  );
    logic [WIDTH-1:0] res;
    res = w;
    case (op)
      OP_SLL:  res = {w[WIDTH-2:0], 1'b0};
      OP_SRL:  res = {1'b0, w[WIDTH-1:1]};
      OP_SRA:  res = {w[WIDTH-1], w[WIDTH-1:1]};
      OP_ROR:  res = {w[0], w[WIDTH-1:1]};
      default: res = w;
    endcase
    return res;
  endfunction

  // State and datapath registers. The working register is cleared on reset
  // so that out_data reads zero while nothing has been computed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_op    <= OP_SLL;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;

    case (r_state)
      ST_IDLE: begin
        if (bus.in_valid) begin
          w_work_nxt = bus.in_data;
          w_op_nxt   = bus.in_op;
          w_cnt_nxt  = bus.in_amt;
          // A zero shift skips SHIFT entirely and presents the operand.
          w_state_nxt = (bus.in_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        w_work_nxt = f_step(r_work, r_op);
        w_cnt_nxt  = r_cnt - SW'(1);
        // The last step is taken on the cycle count reads 1.
        if (r_cnt == SW'(1)) begin
          w_state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.out_data  = r_work;

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle shift unit that applies a shift of 0 to WIDTH-1 positions one bit per clock, under a valid/ready handshake on both sides. It is the sequential, area-lean counterpart of the single-cycle combinational shifters. It sits where latency is acceptable and a full barrel shifter is not, and supports logical left, logical right, arithmetic right and rotate right.

## Interface
- WIDTH, default 8: data width; must be a power of two, ≥ 2.
- SW, derived as log2(WIDTH): shift-amount width. Not overridable.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset: asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at a rising edge.
- in_data  in  WIDTH  operand.
- in_amt  in  SW  shift amount, unsigned.
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA (sign-fill), 11 ROR.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready; result is taken when out_valid && out_ready at a rising edge.
- out_data  out  WIDTH  result.

## Operation
States: IDLE, SHIFT, DONE. The state is registered; in_ready = (state == IDLE), and out_valid = (state == DONE).

- **Reset** (rst_n low, takes effect immediately): state = IDLE, working register = 0, count = 0, out_data = 0, out_valid = 0, in_ready = 1. Inputs are ignored while rst_n is low.
- **IDLE:** on accept, load in_data into the working register, and latch in_op and count = in_amt.
  - If in_amt == 0, go to DONE.
  - Otherwise go to SHIFT.
- **SHIFT:** each cycle, apply a 1-bit step to the working register and decrement count.
  - SLL: {w[WIDTH-2:0], 0}.
  - SRL: {0, w[WIDTH-1:1]}.
  - SRA: {w[WIDTH-1], w[WIDTH-1:1]}.
  - ROR: {w[0], w[WIDTH-1:1]}.
  - On the cycle where count == 1, the step is applied and state goes to DONE.
- **DONE:** out_data = working register, held stable while out_ready is low. On out_valid && out_ready, go to IDLE.
- Ops are never overlapped. in_valid is ignored in SHIFT and DONE; the inputs need not be held after acceptance.
- The result must equal the combinational shift of in_data by in_amt (mod 2^WIDTH for SLL).
- out_data is only meaningful while out_valid is high. Between results it reflects the working register.

## Timing
- **Accept:** the request is captured at edge T, and in_ready falls after T.
- **Latency:** out_valid rises after edge T+in_amt. For in_amt == 0 it rises after edge T, i.e. one cycle after acceptance.
- **Output handshake:** completes at edge U. out_valid falls and in_ready rises after U, so the next accept can occur at edge U+1.
- **Throughput:** with out_ready tied high, one op per in_amt+2 cycles.
- **Reset mid-operation:** when rst_n is asserted in SHIFT or DONE, the op is dropped with no output. out_valid drops asynchronously. The first edge after rst_n rises may accept a new request.
- **No combinational paths:** none from in_* to out_*, and none from out_ready to in_ready.

## Test plan
All scenarios use WIDTH = 8.

1. SLL, in_data 0xB3, amt 3, out_ready = 1 -> out_data 0x98; out_valid rises 3 cycles after accept and is high for 1 cycle; in_ready is low for 4 cycles.
2. SRL then SRA on 0x96, amt 2 -> 0x25 then 0xE5. Also SRA 0x7F, amt 7 -> 0x00, and SRA 0x80, amt 7 -> 0xFF.
3. ROR 0x81, amt 1 -> 0xC0. Any op with amt 0 on 0x5A -> 0x5A, with out_valid one cycle after accept.
4. Backpressure: hold out_ready low for 5 cycles in DONE while toggling in_valid and in_data -> out_valid stays 1, out_data stays stable, in_ready stays 0, and no second op is captured. Release out_ready -> one transfer, then in_ready = 1.
5. Reset mid-SHIFT: SLL 0xFF, amt 7; pull rst_n low after 3 cycles -> out_valid = 0, out_data = 0, in_ready = 1 with no clock. After release, SRL 0xF0, amt 4 -> 0x0F.
6. Random soak: 1000 random in_data/in_amt/in_op values with random valid/ready stalls -> every result matches the reference model, and each accept-to-out_valid gap equals in_amt.
